uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter on the processor data port, alongside the data RAM. It decodes the `ALUResult` address, buffers bytes written to its TXDATA register in a small FIFO, and serialises them 8N1 on `tx`. The top level returns `rd_data` instead of RAM `ReadData` whenever `sel` is high. It also gives software a status register and an optional "transmit done" interrupt.

---
 rtl/uart_tx_mmio_pkg.sv | 25 ++
 rtl/uart_tx_mmio_if.sv | 22 ++
 rtl/uart_tx_mmio_sync_fifo.sv | 49 ++++
 rtl/uart_tx_mmio.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_mmio_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter:
// FSM states, register offsets and STATUS/CTRL bit positions.
package uart_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;

   localparam int STAT_FULL  = 0;
   localparam int STAT_EMPTY = 1;
   localparam int STAT_BUSY  = 2;
   localparam int STAT_OVF   = 3;
   localparam int STAT_CNT   = 4;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_IRQ_EN = 1;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Processor data-port view of the UART peripheral: store/load strobes,
// address and write data in, read data and address-hit select out.
interface uart_tx_mmio_if;

   logic        MemWrite;
   logic        MemRead;
   logic [31:0] ALUResult;
   logic [31:0] WriteData;
   logic [31:0] rd_data;
   logic        sel;

   modport master (
      output MemWrite, MemRead, ALUResult, WriteData,
      input  rd_data, sel
   );

   modport slave (
      input  MemWrite, MemRead, ALUResult, WriteData,
      output rd_data, sel
   );

endinterface

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Single-clock FIFO with same-cycle push/pop; a push at full is accepted
// only when a pop happens in the same cycle, a pop at empty is ignored.
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & (~full | pop);
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage carries no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO, STATUS and CTRL registers.
// Define UART_TX_IRQ_EN to implement CTRL.irq_en and the transmit-done irq.
module uart_tx_mmio
   import uart_tx_pkg::*;
#(
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 8,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0400
) (
   input  logic           clk,
   input  logic           reset_n,
   uart_tx_mmio_if.slave  bus,
   output logic           tx,
   output logic           irq
);

   localparam int CNT_W   = $clog2(CLKS_PER_BIT);
   localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;

   tx_state_t            state;
   logic [CNT_W-1:0]     clk_cnt;
   logic [2:0]           bit_idx;
   logic [7:0]           shift_reg;
   logic                 enable;
   logic                 irq_en;
   logic                 ovf;

   logic                 sel_c;
   logic [1:0]           reg_off;
   logic                 wr_c;
   logic                 push;
   logic                 pop;
   logic                 bit_done;
   logic                 busy;
   logic [7:0]           fifo_dout;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [FIFO_CW-1:0]   fifo_count;
   logic [7:0]           cnt_ext;
   logic [31:0]          status_word;
   logic [31:0]          ctrl_word;
   logic [31:0]          rd_data_c;
   logic                 unused_bits;

   assign sel_c   = (bus.ALUResult[31:4] == BASE_ADDR[31:4]);
   assign reg_off = bus.ALUResult[3:2];
   assign wr_c    = sel_c & bus.MemWrite;
   assign push    = wr_c & (reg_off == REG_TXDATA);

   assign bit_done = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign busy     = (state != ST_IDLE);
   // Pops happen on leaving IDLE or at the last cycle of a stop bit.
   assign pop      = enable & ~fifo_empty &
                     ((state == ST_IDLE) | ((state == ST_STOP) & bit_done));

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .din     (bus.WriteData[7:0]),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         enable <= 1'b1;
         ovf    <= 1'b0;
      end else begin
         if (push & fifo_full & ~pop)
            ovf <= 1'b1;
         else if (wr_c & (reg_off == REG_STATUS) & bus.WriteData[STAT_OVF])
            ovf <= 1'b0;
         if (wr_c & (reg_off == REG_CTRL))
            enable <= bus.WriteData[CTRL_EN];
      end
   end

`ifdef UART_TX_IRQ_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         irq_en <= 1'b0;
         irq    <= 1'b0;
      end else begin
         if (wr_c & (reg_off == REG_CTRL))
            irq_en <= bus.WriteData[CTRL_IRQ_EN];
         irq <= irq_en & fifo_empty & ~busy;
      end
   end
`else
   assign irq_en = 1'b0;
   assign irq    = 1'b0;
`endif

   // Serialiser: tx is registered and updated on the same edge as the state.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         clk_cnt <= '0;
         bit_idx <= '0;
         tx      <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  state     <= ST_START;
                  shift_reg <= fifo_dout;
                  clk_cnt   <= '0;
                  tx        <= 1'b0;
               end
            end
            ST_START: begin
               if (bit_done) begin
                  state   <= ST_DATA;
                  clk_cnt <= '0;
                  bit_idx <= '0;
                  tx      <= shift_reg[0];
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end
            ST_DATA: begin
               if (bit_done) begin
                  clk_cnt <= '0;
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state <= ST_STOP;
                     tx    <= 1'b1;
                  end else begin
                     shift_reg <= {1'b0, shift_reg[7:1]};
                     tx        <= shift_reg[1];
                  end
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end
            ST_STOP: begin
               if (bit_done) begin
                  clk_cnt <= '0;
                  if (pop) begin
                     state     <= ST_START;
                     shift_reg <= fifo_dout;
                     tx        <= 1'b0;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign cnt_ext = 8'(fifo_count);

   always_comb begin
      status_word                  = '0;
      status_word[STAT_FULL]       = fifo_full;
      status_word[STAT_EMPTY]      = fifo_empty;
      status_word[STAT_BUSY]       = busy;
      status_word[STAT_OVF]        = ovf;
      status_word[STAT_CNT +: 4]   = cnt_ext[3:0];
      ctrl_word                    = '0;
      ctrl_word[CTRL_EN]           = enable;
      ctrl_word[CTRL_IRQ_EN]       = irq_en;
   end

   always_comb begin
      rd_data_c = '0;
      if (sel_c & bus.MemRead) begin
         case (reg_off)
            REG_STATUS: rd_data_c = status_word;
            REG_CTRL:   rd_data_c = ctrl_word;
            default:    rd_data_c = '0;
         endcase
      end
   end

   assign bus.rd_data = rd_data_c;
   assign bus.sel     = sel_c;

   assign unused_bits = ^{bus.ALUResult[1:0], bus.WriteData[31:8], cnt_ext[7:4]};

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio (CLKS_PER_BIT=4, FIFO_DEPTH=4); a line
// monitor decodes tx frames and a scoreboard queue holds the expected bytes.
module tb_uart_tx_mmio;

   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;
`ifdef UART_TX_IRQ_EN
   localparam bit IRQ_ON = 1'b1;
`else
   localparam bit IRQ_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic tx;
   logic irq;

   uart_tx_mmio_if bus();

   uart_tx_mmio #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (4),
      .BASE_ADDR    (32'h0000_0400)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus),
      .tx      (tx),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   int         rx_start_q[$];
   int         rx_err = 0;

   logic       mon_active = 1'b0;
   int         mon_cnt = 0;
   int         mon_start = 0;
   logic [9:0] mon_bits = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // Line monitor: samples mid-bit, pushes each received byte and its start cycle.
   always @(negedge clk) begin
      if (!reset_n) begin
         mon_active <= 1'b0;
      end else if (!mon_active) begin
         if (tx === 1'b0) begin
            mon_active <= 1'b1;
            mon_cnt    <= 1;
            mon_start  <= cyc;
         end
      end else begin
         if (mon_cnt % CPB == CPB / 2) mon_bits[mon_cnt / CPB] <= tx;
         if (mon_cnt == FRAME - 1) begin
            if (mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) rx_err <= rx_err + 1;
            rx_q.push_back(mon_bits[8:1]);
            rx_start_q.push_back(mon_start);
            mon_active <= 1'b0;
         end else begin
            mon_cnt <= mon_cnt + 1;
         end
      end
   end

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      bus.ALUResult = addr;
      bus.WriteData = data;
      bus.MemWrite  = 1'b1;
      @(posedge clk);
      #1 bus.MemWrite = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [31:0] d, output logic s);
      @(negedge clk);
      bus.ALUResult = addr;
      bus.MemRead   = 1'b1;
      #1;
      d = bus.rd_data;
      s = bus.sel;
      bus.MemRead = 1'b0;
   endtask

   task automatic push_byte(input logic [7:0] b);
      exp_q.push_back(b);
      bus_write(32'h400, {24'h0, b});
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      exp_q.delete();
      rx_q.delete();
      rx_start_q.delete();
      reset_n = 1'b1;
   endtask

   task automatic check_frames(input int n, input string name, input bit contiguous);
      int prev_start;
      for (int i = 0; i < FRAME * (n + 2) && rx_q.size() < n; i++) @(posedge clk);
      tests++;
      if (rx_q.size() < n) begin
         fails++;
         $display("FAIL %s_timeout: got %0d frames, required %0d", name, rx_q.size(), n);
      end
      prev_start = 0;
      for (int i = 0; i < n && rx_q.size() > 0 && exp_q.size() > 0; i++) begin
         logic [7:0] got;
         logic [7:0] want;
         int         st;
         got  = rx_q.pop_front();
         want = exp_q.pop_front();
         st   = rx_start_q.pop_front();
         tests++;
         if (got !== want) begin
            fails++;
            $display("FAIL %s_byte%0d: got 0x%02h, required 0x%02h", name, i, got, want);
         end
         if (contiguous && i > 0) begin
            tests++;
            if (st - prev_start !== FRAME) begin
               fails++;
               $display("FAIL %s_gap%0d: got %0d cycles between starts, required %0d",
                        name, i, st - prev_start, FRAME);
            end
         end
         prev_start = st;
      end
      tests++;
      if (rx_err !== 0) begin
         fails++;
         $display("FAIL %s_framing: got %0d framing errors, required 0", name, rx_err);
      end
   endtask

   task automatic check_rd(input logic [31:0] addr, input logic [31:0] want, input string name);
      logic [31:0] d;
      logic        s;
      bus_read(addr, d, s);
      tests++;
      if (d !== want) begin
         fails++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, d, want);
      end
   endtask

   task automatic check_bit(input logic got, input logic want, input string name);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %b, required %b", name, got, want);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      check_bit(tx, 1'b1, "reset_tx");
      check_bit(irq, 1'b0, "reset_irq");
      check_rd(32'h404, 32'h02, "reset_status");
      check_rd(32'h408, 32'h01, "reset_ctrl");
   endtask

   task automatic test_single_frame();
      push_byte(8'hA5);
      check_rd(32'h404, 32'h10, "single_status_cnt1");
      @(posedge clk);
      #1 check_bit(tx, 1'b0, "single_start_edge");
      repeat (39) @(posedge clk);
      check_rd(32'h404, 32'h06, "single_busy_last_stop_cycle");
      check_rd(32'h404, 32'h02, "single_status_after");
      check_frames(1, "single", 1'b0);
   endtask

   task automatic test_back_to_back();
      push_byte(8'h01);
      push_byte(8'h80);
      push_byte(8'hFF);
      push_byte(8'h00);
      push_byte(8'h5A);
      bus_write(32'h400, 32'hEE);
      check_rd(32'h404, 32'h4D, "b2b_overflow_status");
      bus_write(32'h404, 32'h8);
      check_rd(32'h404, 32'h45, "b2b_overflow_cleared");
      check_frames(5, "b2b", 1'b1);
      check_rd(32'h404, 32'h02, "b2b_status_drained");
   endtask

   task automatic test_enable();
      logic stayed_high;
      bus_write(32'h408, 32'h0);
      push_byte(8'h3C);
      check_rd(32'h404, 32'h10, "enable_queued_cnt1");
      stayed_high = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1 if (tx !== 1'b1) stayed_high = 1'b0;
      end
      check_bit(stayed_high, 1'b1, "enable_off_tx_idle");
      bus_write(32'h408, 32'h1);
      check_bit(tx, 1'b1, "enable_write_edge_tx");
      @(posedge clk);
      #1 check_bit(tx, 1'b0, "enable_next_edge_start");
      check_frames(1, "enable", 1'b0);
   endtask

   task automatic test_reset_mid_frame();
      logic stayed_high;
      bus_write(32'h400, 32'h00);
      bus_write(32'h400, 32'h55);
      repeat (17) @(posedge clk);
      #1 check_bit(tx, 1'b0, "midrst_in_data_bit3");
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      #1 check_bit(tx, 1'b1, "midrst_tx_high");
      check_rd(32'h404, 32'h02, "midrst_status");
      reset_n = 1'b1;
      stayed_high = 1'b1;
      for (int i = 0; i < 3 * FRAME; i++) begin
         @(posedge clk);
         #1 if (tx !== 1'b1) stayed_high = 1'b0;
      end
      check_bit(stayed_high, 1'b1, "midrst_line_quiet");
      tests++;
      if (rx_q.size() !== 0) begin
         fails++;
         $display("FAIL midrst_no_frames: got %0d frames, required 0", rx_q.size());
      end
      check_rd(32'h408, 32'h01, "midrst_ctrl");
   endtask

   task automatic test_irq();
      bus_write(32'h408, 32'h3);
      check_rd(32'h408, IRQ_ON ? 32'h3 : 32'h1, "irq_ctrl_read");
      @(posedge clk);
      #1 check_bit(irq, IRQ_ON, "irq_idle_empty");
      push_byte(8'h81);
      check_bit(irq, IRQ_ON, "irq_write_edge");
      @(posedge clk);
      #1 check_bit(irq, 1'b0, "irq_cleared_after_write");
      repeat (39) @(posedge clk);
      #1 check_bit(irq, 1'b0, "irq_last_stop_cycle");
      @(posedge clk);
      #1 check_bit(irq, 1'b0, "irq_busy_just_dropped");
      @(posedge clk);
      #1 check_bit(irq, IRQ_ON, "irq_after_stop");
      check_frames(1, "irq_first", 1'b0);
      push_byte(8'h7E);
      check_bit(irq, IRQ_ON, "irq_second_write_edge");
      @(posedge clk);
      #1 check_bit(irq, 1'b0, "irq_second_cleared");
      check_frames(1, "irq_second", 1'b0);
      bus_write(32'h408, 32'h1);
   endtask

   task automatic test_decode();
      logic [31:0] d;
      logic        s;
      bus_read(32'h40C, d, s);
      check_bit(s, 1'b1, "decode_40c_sel");
      tests++;
      if (d !== 32'h0) begin
         fails++;
         $display("FAIL decode_40c_data: got 0x%08h, required 0x00000000", d);
      end
      bus_read(32'h500, d, s);
      check_bit(s, 1'b0, "decode_500_sel");
      check_rd(32'h400, 32'h0, "decode_txdata_read");
      bus_write(32'h500, 32'h77);
      bus_write(32'h508, 32'h0);
      bus_write(32'h504, 32'h8);
      bus_write(32'h40C, 32'hFF);
      check_rd(32'h404, 32'h02, "decode_status_unchanged");
      check_rd(32'h408, 32'h01, "decode_ctrl_unchanged");
      repeat (8) @(posedge clk);
      #1 check_bit(tx, 1'b1, "decode_tx_idle");
   endtask

   initial begin
      bus.MemWrite  = 1'b0;
      bus.MemRead   = 1'b0;
      bus.ALUResult = '0;
      bus.WriteData = '0;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_enable();
      test_reset_mid_frame();
      test_irq();
      test_decode();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

endmodule
